// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, the neuron state encoding and the membrane ceiling
// for the leaky integrate-and-fire core.
//   TAU_W / WEIGHT_W / THR_W : widths of the loader's configuration words
//   VMEM_W                   : membrane potential width (unsigned)
//   VMEM_MAX                 : saturation ceiling of the membrane potential
//   lif_state_t              : INTEGRATE / FIRE / REFRACTORY
package lif_pkg;

  localparam int TAU_W    = 15;
  localparam int WEIGHT_W = 11;
  localparam int THR_W    = 15;
  localparam int VMEM_W   = 16;

  localparam logic [VMEM_W-1:0] VMEM_MAX = '1;

  typedef enum logic [1:0] {
    INTEGRATE  = 2'd0,
    FIRE       = 2'd1,
    REFRACTORY = 2'd2
  } lif_state_t;

endpackage

// File: rtl/lif_leak_timer.sv
// lif_leak_timer: tau-period counter that produces the leak_evt pulse.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   i_clear    : force the counter to 0 this edge (also holds it at 0)
//   i_tau      : captured leak period in cycles, 0 disables leaking
//   o_leak_evt : high in the cycle whose edge applies a leak
module lif_leak_timer
  import lif_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [TAU_W-1:0] i_tau,
  output logic             o_leak_evt
);

  logic [TAU_W-1:0] r_cnt;

  assign o_leak_evt = (i_tau != '0) && (r_cnt == (i_tau - TAU_W'(1)));

  // Counter runs 0..tau-1 and wraps on the leak event; tau==0 parks it at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_leak_evt || (i_tau == '0)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TAU_W'(1);
    end
  end

endmodule

// File: rtl/lif_neuron_core.sv
// lif_neuron_core: leaky integrate-and-fire neuron fed by the serial config
// loader. Weighted input spikes accumulate into an unsigned, saturating
// membrane potential; a periodic shift leak is applied before each add; a
// threshold crossing emits a one-cycle spike followed by a refractory period.
// Optional build macro: LIF_SPIKE_COUNT_EN adds the spike_count output.
// Ports:
//   clk         : system clock, all state on posedge
//   rst         : asynchronous active-low reset
//   cfg_load    : capture tau/weight/threshold (highest priority)
//   tau         : leak period in cycles (0 = no leak)
//   weight      : unsigned increment per input spike
//   threshold   : fire level (0 = never fire)
//   spike_in    : input spike, sampled each posedge
//   spike_out   : registered one-cycle fire pulse
//   v_mem       : membrane potential
//   refractory  : high while in FIRE or REFRACTORY
//   spike_count : fire count modulo 2^COUNT_W (LIF_SPIKE_COUNT_EN only)
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int LEAK_SHIFT     = 4,
  parameter int REFRACT_CYCLES = 3,
  parameter int COUNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_load,
  input  logic [TAU_W-1:0]    tau,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [THR_W-1:0]    threshold,
  input  logic                spike_in,
  output logic                spike_out,
  output logic [VMEM_W-1:0]   v_mem,
  output logic                refractory
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [COUNT_W-1:0]  spike_count
`endif
);

  localparam int RC_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

  logic [TAU_W-1:0]    r_tau;
  logic [WEIGHT_W-1:0] r_weight;
  logic [THR_W-1:0]    r_thr;
  logic [VMEM_W-1:0]   r_v;
  logic                r_spike;
  lif_state_t          r_state;
  logic [RC_W-1:0]     r_rcnt;

  lif_state_t          w_state_nxt;
  logic [VMEM_W-1:0]   w_v_nxt;
  logic                w_spike_nxt;
  logic [RC_W-1:0]     w_rcnt_nxt;
  logic                w_cross;
  logic                w_leak_evt;
  logic                w_timer_clr;

  function automatic logic [VMEM_W-1:0] apply_leak(input logic [VMEM_W-1:0] v,
                                                   input logic evt);
    return evt ? (v - (v >> LEAK_SHIFT)) : v;
  endfunction

  // 17-bit sum clamped to the ceiling instead of wrapping.
  function automatic logic [VMEM_W-1:0] sat_add(input logic [VMEM_W-1:0] a,
                                                input logic [WEIGHT_W-1:0] b);
    logic [VMEM_W:0] s;
    s = {1'b0, a} + {{(VMEM_W + 1 - WEIGHT_W){1'b0}}, b};
    return s[VMEM_W] ? VMEM_MAX : s[VMEM_W-1:0];
  endfunction

  assign w_cross     = (r_thr != '0) && (r_v >= {1'b0, r_thr});
  // The leak phase only advances on ordinary integrate cycles.
  assign w_timer_clr = cfg_load || (r_state != INTEGRATE) || w_cross;

  lif_leak_timer u_leak_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_timer_clr),
    .i_tau      (r_tau),
    .o_leak_evt (w_leak_evt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_spike_nxt = 1'b0;
    w_rcnt_nxt  = r_rcnt;
    if (cfg_load) begin
      w_state_nxt = INTEGRATE;
      w_v_nxt     = '0;
    end else begin
      case (r_state)
        INTEGRATE: begin
          if (w_cross) begin
            w_v_nxt     = '0;
            w_spike_nxt = 1'b1;
            w_state_nxt = FIRE;
          end else begin
            w_v_nxt = sat_add(apply_leak(r_v, w_leak_evt),
                              spike_in ? r_weight : '0);
          end
        end
        FIRE: begin
          if (REFRACT_CYCLES == 0) begin
            w_state_nxt = INTEGRATE;
          end else begin
            w_state_nxt = REFRACTORY;
            w_rcnt_nxt  = RC_W'(REFRACT_CYCLES - 1);
          end
        end
        REFRACTORY: begin
          w_v_nxt = '0;
          if (r_rcnt == '0) begin
            w_state_nxt = INTEGRATE;
          end else begin
            w_rcnt_nxt = r_rcnt - RC_W'(1);
          end
        end
        default: begin
          w_state_nxt = INTEGRATE;
          w_v_nxt     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INTEGRATE;
      r_rcnt  <= '0;
      r_spike <= 1'b0;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_spike <= w_spike_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tau    <= '0;
      r_weight <= '0;
      r_thr    <= '0;
    end else if (cfg_load) begin
      r_tau    <= tau;
      r_weight <= weight;
      r_thr    <= threshold;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (cfg_load) begin
      r_count <= '0;
    end else if ((r_state == INTEGRATE) && w_cross) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign spike_count = r_count;
`endif

  assign spike_out  = r_spike;
  assign v_mem      = r_v;
  assign refractory = (r_state != INTEGRATE);

endmodule
